pattern_loader: RTL and testbench

Command-frame parser that sits directly upstream of the serial pattern output stage. It consumes bytes from the UART receiver, assembles the DATA_BIT-bit output pattern and frequency pattern (LSB byte first), and drives the start/stop/mode controls and both pattern buses of the serial output stage. Partially received frames never disturb the pattern buses, and malformed frames never disturb them either.

---
 rtl/pattern_loader.sv | 144 ++++++++++++++
 tb/tb_pattern_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_loader.sv
// Command-frame parser feeding the serial pattern output stage: assembles the
// output and frequency patterns from received bytes and issues start/stop/error strobes.
module pattern_loader #(
  parameter int DATA_BIT = 32,
  parameter int TIMEOUT  = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_done_tick,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_mode,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_err_tick,
  output logic                o_busy
);
  localparam int NB = DATA_BIT / 8;
  localparam int BW = $clog2(NB + 1);
  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_OUT_PAT, S_FREQ_PAT, S_ISSUE} state_t;

  state_t              state_reg, state_next;
  logic [BW-1:0]       byte_cnt_reg, byte_cnt_next;
  logic [GW-1:0]       gap_reg, gap_next, gap_inc;
  logic                mode_sh_reg, mode_sh_next;
  logic [DATA_BIT-1:0] out_sh_reg, freq_sh_reg;
  logic                out_we, freq_we, sh_clear, issue;
  logic                start_next, stop_next, err_next;
  logic                last_byte, timeout_hit;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_next      = gap_reg;
    mode_sh_next  = mode_sh_reg;
    start_next    = 1'b0;
    stop_next     = 1'b0;
    err_next      = 1'b0;
    out_we        = 1'b0;
    freq_we       = 1'b0;
    sh_clear      = 1'b0;
    issue         = 1'b0;
    gap_inc       = gap_reg + GW'(1);
    last_byte     = (byte_cnt_reg == BW'(NB - 1));
    // The counter value this clock would reach decides the timeout, so a byte
    // landing in that same clock still wins.
    timeout_hit   = (gap_inc == GW'(TIMEOUT - 1));
    case (state_reg)
      S_IDLE: begin
        gap_next = '0;
        if (i_rx_done_tick) begin
          if (i_rx_data == 8'h01 || i_rx_data == 8'h02) begin
            mode_sh_next  = i_rx_data[1];
            byte_cnt_next = '0;
            state_next    = S_OUT_PAT;
          end else if (i_rx_data == 8'h03) begin
            stop_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_OUT_PAT, S_FREQ_PAT: begin
        if (i_rx_done_tick) begin
          gap_next = '0;
          out_we   = (state_reg == S_OUT_PAT);
          freq_we  = (state_reg == S_FREQ_PAT);
          if (last_byte) begin
            byte_cnt_next = '0;
            state_next    = (state_reg == S_OUT_PAT) ? S_FREQ_PAT : S_ISSUE;
          end else begin
            byte_cnt_next = byte_cnt_reg + BW'(1);
          end
        end else if (timeout_hit) begin
          err_next      = 1'b1;
          sh_clear      = 1'b1;
          gap_next      = '0;
          byte_cnt_next = '0;
          mode_sh_next  = 1'b0;
          state_next    = S_IDLE;
        end else begin
          gap_next = gap_inc;
        end
      end
      S_ISSUE: begin
        issue      = 1'b1;
        start_next = 1'b1;
        gap_next   = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      byte_cnt_reg     <= '0;
      gap_reg          <= '0;
      mode_sh_reg      <= 1'b0;
      o_start          <= 1'b0;
      o_stop           <= 1'b0;
      o_err_tick       <= 1'b0;
      o_busy           <= 1'b0;
      o_mode           <= 1'b0;
      o_output_pattern <= '0;
      o_freq_pattern   <= '0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_reg      <= gap_next;
      mode_sh_reg  <= mode_sh_next;
      o_start      <= start_next;
      o_stop       <= stop_next;
      o_err_tick   <= err_next;
      o_busy       <= (state_next != S_IDLE);
      if (issue) begin
        o_mode           <= mode_sh_reg;
        o_output_pattern <= out_sh_reg;
        o_freq_pattern   <= freq_sh_reg;
      end
    end
  end

  // One byte lane per generate iteration; little-endian lane select by byte_cnt.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_sh_reg[8*gi +: 8]  <= 8'h00;
        freq_sh_reg[8*gi +: 8] <= 8'h00;
      end else if (sh_clear) begin
        out_sh_reg[8*gi +: 8]  <= 8'h00;
        freq_sh_reg[8*gi +: 8] <= 8'h00;
      end else if (byte_cnt_reg == BW'(gi)) begin
        if (out_we)  out_sh_reg[8*gi +: 8]  <= i_rx_data;
        if (freq_we) freq_sh_reg[8*gi +: 8] <= i_rx_data;
      end
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader: a byte-stream frame interpreter predicts
// each strobe and its clock; a monitor checks strobes and held outputs.
module tb_pattern_loader;
  localparam int DATA_BIT = 32;
  localparam int TIMEOUT  = 16;
  localparam int NB       = DATA_BIT / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_tick = 1'b0;
  logic                o_start, o_stop, o_mode, o_err_tick, o_busy;
  logic [DATA_BIT-1:0] o_output_pattern, o_freq_pattern;

  pattern_loader #(.DATA_BIT(DATA_BIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done_tick(rx_tick),
    .o_start(o_start), .o_stop(o_stop), .o_mode(o_mode),
    .o_output_pattern(o_output_pattern), .o_freq_pattern(o_freq_pattern),
    .o_err_tick(o_err_tick), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                  kind;  // 0 start, 1 stop, 2 error
    int                  cyc;
    logic [DATA_BIT-1:0] pat;
    logic [DATA_BIT-1:0] freq;
    logic                mode;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state: frame collection over plain byte queues.
  bit         in_frame = 0;
  bit         m_mode = 0;
  logic [7:0] coll[$];
  int         last_edge = 0;
  int         done_edge = -10;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    logic [DATA_BIT-1:0] p, f;
    p = '0;
    f = '0;
    if (kind == 0)
      for (int k = 0; k < NB; k++) begin
        p = p + (DATA_BIT'(coll[k]) << (8 * k));
        f = f + (DATA_BIT'(coll[NB + k]) << (8 * k));
      end
    e.kind = kind; e.cyc = at; e.pat = p; e.freq = f; e.mode = m_mode;
    sb.push_back(e);
  endtask

  // Interprets one clock edge of the input stream at edge index e.
  task automatic model_edge(input bit has, input logic [7:0] b, input int e);
    if (has) begin
      if (in_frame) begin
        coll.push_back(b);
        last_edge = e;
        if (coll.size() == 2 * NB) begin
          push_ev(0, e + 1);
          in_frame  = 0;
          done_edge = e;
        end
      end else if (e == done_edge + 1) begin
        // byte during the issue clock is dropped
      end else if (b == 8'h01 || b == 8'h02) begin
        in_frame  = 1;
        m_mode    = (b == 8'h02);
        coll.delete();
        last_edge = e;
      end else if (b == 8'h03) begin
        push_ev(1, e);
      end else begin
        push_ev(2, e);
      end
    end else if (in_frame && (e - last_edge) == TIMEOUT - 1) begin
      push_ev(2, e);
      in_frame = 0;
    end
  endtask

  task automatic step(input bit has, input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_tick = has;
    rx_data = has ? b : 8'($urandom);
    model_edge(has, b, cyc + 1);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {o_start, o_stop, o_err_tick, o_busy, o_mode}, 5'b0);
    chk({tag, "_pat"}, o_output_pattern, 0);
    chk({tag, "_freq"}, o_freq_pattern, 0);
  endtask

  // Monitor: strobes are popped from the scoreboard and checked for kind and clock.
  logic [DATA_BIT-1:0] held_pat = '0, held_freq = '0;
  logic                held_mode = 1'b0;
  always @(negedge clk) begin
    int  n, kind;
    ev_t e;
    if (!rst_n) begin
      held_pat = '0; held_freq = '0; held_mode = 1'b0;
    end else begin
      n = int'(o_start) + int'(o_stop) + int'(o_err_tick);
      kind = o_start ? 0 : (o_stop ? 1 : 2);
      if (n > 1) chk("exclusive_strobes", n, 1);
      if (n > 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", kind, 3);
        end else begin
          e = sb.pop_front();
          chk("strobe_kind", kind, e.kind);
          chk("strobe_cycle", cyc, e.cyc);
          if (kind == 0 && e.kind == 0) begin
            held_pat = e.pat; held_freq = e.freq; held_mode = e.mode;
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("missed_strobe", 3, e.kind);
      end
      chk("held_outputs", {o_mode, o_output_pattern, o_freq_pattern},
          {held_mode, held_pat, held_freq});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    int         gap, len;

    #15;
    chk_all_zero("in_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    idle(6);
    chk_all_zero("after_reset");

    // One-shot load
    send(8'h01, 0);
    foreach (coll[i]) ;
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h0F, 1); send(8'h00, 0); send(8'h00, 2); send(8'hF0, 0);
    idle(3);
    chk("oneshot_pat", o_output_pattern, 32'hDDCCBBAA);
    chk("oneshot_freq", o_freq_pattern, 32'hF000000F);
    chk("oneshot_mode", o_mode, 1'b0);

    // Repeat load then stop
    send(8'h02, 0);
    for (int i = 0; i < 2 * NB; i++) send(8'(8'h10 + i), 0);
    idle(3);
    chk("repeat_mode", o_mode, 1'b1);
    chk("repeat_pat", o_output_pattern, 32'h13121110);
    send(8'h03, 3);
    chk("stop_mode_held", o_mode, 1'b1);

    // In-frame 0x03 is data; unknown command is an error
    send(8'h01, 0);
    repeat (NB) send(8'h03, 0);
    repeat (NB) send(8'h00, 0);
    idle(3);
    chk("inframe03_pat", o_output_pattern, 32'h03030303);
    send(8'h7E, 0);
    step(1'b0, 8'h00);
    #2;
    chk("unknown_busy", o_busy, 1'b0);
    idle(2);

    // Timeout after three payload bytes; then a byte exactly on the boundary
    send(8'h01, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    idle(TIMEOUT + 4);
    chk("timeout_idle", o_busy, 1'b0);
    chk("timeout_pat_held", o_output_pattern, 32'h03030303);
    send(8'h01, 0); send(8'h44, 0); send(8'h55, TIMEOUT - 2);
    send(8'h66, 0); send(8'h77, 0);
    repeat (NB) send(8'h5A, 0);
    idle(3);
    chk("boundary_pat", o_output_pattern, 32'h77665544);

    // Back-to-back frames, command immediately after the issue clock
    send(8'h02, 0);
    for (int i = 0; i < 2 * NB; i++) send(8'(8'hC0 + i), 0);
    send(8'h99, 0);
    send(8'h03, 4);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'h01;
        4, 5, 6:    cmd = 8'h02;
        7, 8:       cmd = 8'h03;
        default:    cmd = 8'($urandom_range(4, 255));
      endcase
      len = (cmd == 8'h01 || cmd == 8'h02) ? 2 * NB : 0;
      if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 2 * NB - 1);
      send(cmd, $urandom_range(0, 2));
      for (int i = 0; i < len; i++) begin
        gap = ($urandom_range(0, 11) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
        send(8'($urandom), gap);
      end
      idle((len < 2 * NB && len > 0) ? TIMEOUT + 2 : $urandom_range(0, 3));
    end
    idle(TIMEOUT + 4);

    // Reset mid-frame, then a full frame loads correctly
    send(8'h01, 0);
    for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 0);
    chk("midframe_busy", o_busy, 1'b1);
    @(posedge clk); #1;
    rx_tick = 1'b0;
    rst_n   = 1'b0;
    in_frame = 0; done_edge = -10;
    sb.delete();
    #1;
    chk_all_zero("midframe_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    send(8'h02, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'hFF, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h00, 0);
    idle(3);
    chk("post_reset_pat", o_output_pattern, 32'h04030201);
    chk("post_reset_freq", o_freq_pattern, 32'h00FF00FF);
    chk("post_reset_mode", o_mode, 1'b1);

    idle(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
